stream_upsize_buf: RTL

//  Full-throughput width upsizer: packs T_DATA_RATIO narrow beats into one wide word with per-lane keep.

---
 rtl/stream_pkg.sv | 16 +
 rtl/stream_out_reg.sv | 29 ++
 rtl/stream_upsize_buf.sv | 126 ++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared helpers for the stream datapath library: lane index sizing.
package stream_pkg;

  // Upper bound on lane index width anywhere in the stream library.
  localparam int unsigned LANE_IDX_MAX_W = 8;

  // Generic lane index. Blocks narrow it to their own idx_width() locally.
  typedef logic [LANE_IDX_MAX_W-1:0] lane_idx_t;

  // Width of a counter addressing n lanes. A single-lane block still gets a
  // 1-bit index so that no zero-width vectors appear.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Output holding register for a valid/ready stream.
// A load captures a new word and raises valid. Without a load, an accepted
// word drops valid. Otherwise the word is held stable.
module stream_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  // Load / drain / hold of the registered output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_upsize_buf.sv
// Width upsizer: packs T_DATA_RATIO narrow beats into one wide word with
// per-lane keep. s_last_i closes a word early. An accumulator feeds an output
// holding register, so the input keeps flowing while the output stalls.
module stream_upsize_buf
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned T_DATA_RATIO = 4,
  parameter int unsigned T_USER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_USER_WIDTH-1:0] s_user_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO],
  output logic [T_DATA_RATIO-1:0] m_keep_o,
  output logic [T_USER_WIDTH-1:0] m_user_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int unsigned IDX_W     = idx_width(T_DATA_RATIO);
  localparam int unsigned LAST_LANE = T_DATA_RATIO - 1;
  localparam int unsigned DW_TOT    = T_DATA_WIDTH * T_DATA_RATIO;
  localparam int unsigned PW        = DW_TOT + T_DATA_RATIO + T_USER_WIDTH + 1;

  typedef logic [IDX_W-1:0] idx_t;

  idx_t                    idx;
  logic [T_DATA_WIDTH-1:0] acc_data [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] acc_keep;
  logic [T_USER_WIDTH-1:0] acc_user;
  logic                    acc_last;
  logic                    acc_done;

  logic                    out_free;
  logic                    accept;
  logic                    move;
  logic                    close;
  logic [PW-1:0]           out_d;
  logic [PW-1:0]           out_q;

  assign out_free  = !m_valid_o || m_ready_i;
  assign s_ready_o = !acc_done || out_free;
  assign accept    = s_valid_i && s_ready_o;
  assign move      = acc_done && out_free;
  assign close     = (idx == idx_t'(LAST_LANE)) || s_last_i;

  // Accumulator: lane fill, word close and hand-off to the output register.
  // A move clears the keep mask first. A beat accepted on the same edge then
  // sets lane 0, which is the lane idx points at whenever acc_done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      acc_keep <= '0;
      acc_user <= '0;
      acc_last <= 1'b0;
      acc_done <= 1'b0;
      for (int unsigned i = 0; i < T_DATA_RATIO; i++) begin
        acc_data[i] <= '0;
      end
    end else begin
      if (move) begin
        acc_done <= 1'b0;
        acc_keep <= '0;
      end
      if (accept) begin
        for (int unsigned i = 0; i < T_DATA_RATIO; i++) begin
          if (idx == idx_t'(i)) begin
            acc_data[i] <= s_data_i;
            acc_keep[i] <= 1'b1;
          end
        end
        if (idx == '0) begin
          acc_user <= s_user_i;
        end
        if (close) begin
          acc_done <= 1'b1;
          acc_last <= s_last_i;
          idx      <= '0;
        end else begin
          idx      <= idx + 1'b1;
        end
      end
    end
  end

  // Pack the finished word. Lanes without keep are forced to zero.
  always_comb begin
    out_d = '0;
    for (int unsigned i = 0; i < T_DATA_RATIO; i++) begin
      out_d[i*T_DATA_WIDTH +: T_DATA_WIDTH] = acc_keep[i] ? acc_data[i] : '0;
    end
    out_d[DW_TOT +: T_DATA_RATIO]                = acc_keep;
    out_d[DW_TOT+T_DATA_RATIO +: T_USER_WIDTH]   = acc_user;
    out_d[PW-1]                                  = acc_last;
  end

  stream_out_reg #(
    .WIDTH (PW)
  ) u_out_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (move),
    .d     (out_d),
    .ready (m_ready_i),
    .valid (m_valid_o),
    .q     (out_q)
  );

  // Unpack the held word onto the output ports.
  always_comb begin
    for (int unsigned i = 0; i < T_DATA_RATIO; i++) begin
      m_data_o[i] = out_q[i*T_DATA_WIDTH +: T_DATA_WIDTH];
    end
  end

  assign m_keep_o = out_q[DW_TOT +: T_DATA_RATIO];
  assign m_user_o = out_q[DW_TOT+T_DATA_RATIO +: T_USER_WIDTH];
  assign m_last_o = out_q[PW-1];

endmodule
